// File: rtl/readout_scheduler.sv
// rtl/readout_scheduler.sv - frame-based readout arbiter over 8 FWFT channel FIFOs; define READOUT_SCHED_RR_EN for round-robin grants
module readout_scheduler #(
  parameter int DW        = 120,
  parameter int FRAME_MAX = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [11:0]     period_th,
  input  logic [11:0]     idle_frames_th,
  input  logic [4:0]      ch_quota,
  input  logic [7:0]      ch_empty,
  input  logic [8*DW-1:0] ch_data,
  output logic [7:0]      ch_rd,
  output logic [DW-1:0]   out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic [7:0]      frame_count,
  output logic [7:0]      overrun_cnt,
  output logic            busy
);

  localparam logic [7:0] FMAX = 8'(FRAME_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_ARB,
    S_DATA,
    S_TRAILER
  } state_t;

  state_t          state, state_n;
  logic [11:0]     tmr, idle_cnt;
  logic [7:0]      mask, total;
  logic [2:0]      gnt, sel;
  logic [4:0]      qleft;
  logic            tick, slot_free, start_frame, grant, rd_ok;
  logic            ld, ld_last;
  logic [DW-1:0]   ld_word;
  logic [DW-5:0]   head;

  assign tick        = (tmr == period_th);
  assign slot_free   = ~out_valid | out_ready;
  assign start_frame = (ch_empty != 8'hFF) || (idle_cnt == idle_frames_th);
  assign grant       = (state == S_ARB) && (mask != 8'd0) && (total != FMAX);
  assign head        = ch_data[int'(gnt)*DW +: DW-4];
  assign rd_ok       = (state == S_DATA) && slot_free && !ch_empty[gnt] &&
                       (qleft != 5'd0) && (total < FMAX) && !reset;
  assign busy        = (state != S_IDLE);

`ifdef READOUT_SCHED_RR_EN
  logic [2:0] rr_ptr;

  // Round-robin pick: nearest requesting channel above the last granted one, wrapping
  always_comb begin
    sel = rr_ptr;
    for (int k = 8; k >= 1; k--) begin
      if (mask[rr_ptr + 3'(k)]) sel = rr_ptr + 3'(k);
    end
  end

  // Pointer remembers the last granted channel across frames
  always_ff @(posedge clk) begin
    if (reset)      rr_ptr <= 3'd0;
    else if (grant) rr_ptr <= sel;
  end
`else
  // Fixed priority pick: highest-indexed requesting channel
  always_comb begin
    sel = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) sel = 3'(i);
    end
  end
`endif

  // Next-state, read strobe and output-word selection
  always_comb begin
    state_n = state;
    ch_rd   = 8'd0;
    ld      = 1'b0;
    ld_last = 1'b0;
    ld_word = '0;
    case (state)
      S_IDLE: begin
        if (tick && start_frame) state_n = S_HEADER;
      end
      S_HEADER: begin
        if (slot_free) begin
          ld      = 1'b1;
          ld_word = {8'hA5, frame_count, mask, {(DW-24){1'b0}}};
          state_n = S_ARB;
        end
      end
      S_ARB: begin
        state_n = grant ? S_DATA : S_TRAILER;
      end
      S_DATA: begin
        if (slot_free) begin
          if (rd_ok) begin
            ch_rd[gnt] = 1'b1;
            ld         = 1'b1;
            ld_word    = {1'b1, gnt, head};
            // Leave as soon as quota or frame budget is used up; an emptied
            // channel is only visible on the following cycle.
            if (qleft == 5'd1 || total == FMAX - 8'd1) state_n = S_ARB;
          end else begin
            state_n = S_ARB;
          end
        end
      end
      S_TRAILER: begin
        if (slot_free) begin
          ld      = 1'b1;
          ld_last = 1'b1;
          ld_word = {8'h5A, total, ~ch_empty, {(DW-24){1'b0}}};
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Timer, frame bookkeeping, grant state and the one-deep output register
  always_ff @(posedge clk) begin
    if (reset) begin
      tmr         <= 12'd0;
      idle_cnt    <= 12'd0;
      mask        <= 8'd0;
      total       <= 8'd0;
      gnt         <= 3'd0;
      qleft       <= 5'd0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      frame_count <= 8'd0;
      overrun_cnt <= 8'd0;
    end else begin
      tmr <= tick ? 12'd0 : tmr + 12'd1;
      if (state == S_IDLE) begin
        total <= 8'd0;
        if (tick) begin
          mask     <= ~ch_empty;
          idle_cnt <= start_frame ? 12'd0 : idle_cnt + 12'd1;
        end
      end else if (tick && overrun_cnt != 8'hFF) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
      if (grant) begin
        gnt       <= sel;
        mask[sel] <= 1'b0;
        qleft     <= (ch_quota == 5'd0) ? 5'd1 : ch_quota;
      end
      if (rd_ok) begin
        qleft <= qleft - 5'd1;
        total <= total + 8'd1;
      end
      if (state == S_TRAILER && slot_free) frame_count <= frame_count + 8'd1;
      if (ld) begin
        out_data  <= ld_word;
        out_valid <= 1'b1;
        out_last  <= ld_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_readout_scheduler.sv
// tb/tb_readout_scheduler.sv - self-checking bench for readout_scheduler against a frame-level reference model
module tb_readout_scheduler;

  localparam int DW = 120;
  localparam int FM = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [11:0]     period_th, idle_frames_th;
  logic [4:0]      ch_quota;
  logic [7:0]      ch_empty;
  logic [8*DW-1:0] ch_data;
  logic [7:0]      ch_rd;
  logic [DW-1:0]   out_data;
  logic            out_valid, out_ready, out_last;
  logic [7:0]      frame_count, overrun_cnt;
  logic            busy;

  always #5 clk = ~clk;

  readout_scheduler #(.DW(DW), .FRAME_MAX(FM)) dut (
    .clk(clk), .reset(reset), .period_th(period_th), .idle_frames_th(idle_frames_th),
    .ch_quota(ch_quota), .ch_empty(ch_empty), .ch_data(ch_data), .ch_rd(ch_rd),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .frame_count(frame_count), .overrun_cnt(overrun_cnt), .busy(busy)
  );

  // Upstream FIFOs, a scratch copy for prediction, and expected output words
  logic [DW-1:0] fifo [8][$];
  logic [DW-1:0] cp   [8][$];
  logic [DW-1:0] exp_d [$];
  int            exp_k [$];   // 0 header, 1 data, 2 trailer

  int n_cmp = 0, n_bad = 0;
  int exp_fc, trailers, rd_total, data_total, rr_last;
  int rdy_mode, low_run;
  logic [7:0]    rd_s;
  logic          prev_stall, prev_l;
  logic [DW-1:0] prev_d;

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(string tag, int obs, int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_fifos();
    for (int i = 0; i < 8; i++) begin
      ch_empty[i] = (fifo[i].size() == 0);
      ch_data[i*DW +: DW] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
    end
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < 8; i++) fifo[i].delete();
    drive_fifos();
  endtask

  task automatic fill(int ch, int n);
    logic [127:0] r;
    for (int j = 0; j < n; j++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      fifo[ch].push_back(r[DW-1:0]);
    end
  endtask

  // Predict a whole frame from the FIFO contents at snapshot time
  task automatic build_frame();
    logic [7:0]    m, ne;
    logic [DW-1:0] w;
    int q, tot, n, ch, st;
    for (int i = 0; i < 8; i++) begin
      cp[i] = fifo[i];
      m[i]  = (fifo[i].size() != 0);
    end
    q   = (ch_quota == 5'd0) ? 1 : int'(ch_quota);
    tot = 0;
    st  = rr_last;
    exp_d.push_back({8'hA5, 8'(exp_fc), m, {(DW-24){1'b0}}});
    exp_k.push_back(0);
    for (int j = 0; j < 8; j++) begin
`ifdef READOUT_SCHED_RR_EN
      ch = (st + 1 + j) % 8;
`else
      ch = 7 - j + (st - st);
`endif
      if (m[ch] && tot < FM) begin
        n = q;
        if (cp[ch].size() < n) n = cp[ch].size();
        if (FM - tot < n) n = FM - tot;
        for (int k = 0; k < n; k++) begin
          w = cp[ch].pop_front();
          exp_d.push_back({1'b1, 3'(ch), w[DW-5:0]});
          exp_k.push_back(1);
          tot++;
        end
        rr_last = ch;
      end
    end
    for (int i = 0; i < 8; i++) ne[i] = (cp[i].size() != 0);
    exp_d.push_back({8'h5A, 8'(tot), ne, {(DW-24){1'b0}}});
    exp_k.push_back(2);
  endtask

  task automatic check_word(logic [DW-1:0] d, logic l);
    int k;
    if (exp_d.size() == 0) build_frame();
    k = exp_k.pop_front();
    chk("frame_word", d, exp_d.pop_front());
    chki("out_last", int'(l), (k == 2) ? 1 : 0);
    if (k == 1) data_total++;
    if (k == 2) begin
      trailers++;
      exp_fc = (exp_fc + 1) % 256;
      chki("frame_count", int'(frame_count), exp_fc);
      chki("rd_pulses_vs_words", rd_total, data_total);
    end
  endtask

  // One clock: sample before the edge, then apply pops and new inputs on the falling edge
  task automatic step();
    logic acc, l, rst_s, legal;
    logic [DW-1:0] d;
    #1;
    rd_s  = ch_rd;
    acc   = out_valid & out_ready;
    d     = out_data;
    l     = out_last;
    rst_s = reset;
    legal = ($countones(rd_s) <= 1) && ((rd_s & ch_empty) == 8'd0) &&
            (rd_s == 8'd0 || !out_valid || out_ready);
    chki("ch_rd_legal", int'(legal), 1);
    if (prev_stall) begin
      chk("hold_data", d, prev_d);
      chki("hold_last", int'(l), int'(prev_l));
      chki("hold_valid", int'(out_valid), 1);
    end
    prev_stall = out_valid & ~out_ready;
    prev_d     = d;
    prev_l     = l;
    rd_total  += $countones(rd_s);
    @(posedge clk);
    @(negedge clk);
    if (rst_s) begin
      exp_d.delete();
      exp_k.delete();
      prev_stall = 1'b0;
    end else if (acc) begin
      check_word(d, l);
    end
    for (int i = 0; i < 8; i++) begin
      if (rd_s[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
    end
    drive_fifos();
    if (rdy_mode == 0) begin
      out_ready = 1'b1;
    end else begin
      out_ready = (low_run >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
      low_run   = out_ready ? 0 : low_run + 1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset      = 1'b0;
    exp_fc     = 0;
    rr_last    = 0;
    rd_total   = 0;
    data_total = 0;
    prev_stall = 1'b0;
  endtask

  task automatic wait_trailers(int target, int bound, string tag);
    int n;
    n = 0;
    while (trailers < target && n < bound) begin
      step();
      n++;
    end
    chki(tag, int'(trailers >= target), 1);
  endtask

  initial begin
    int n, flen, exp_ovr;
    reset = 1'b1; out_ready = 1'b1; rdy_mode = 0; low_run = 0;
    period_th = 12'd63; idle_frames_th = 12'd2; ch_quota = 5'd16;
    trailers = 0; rd_s = 8'd0; prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
    clear_fifos();
    do_reset();

    // Reset values
    chki("rst_out_valid", int'(out_valid), 0);
    chki("rst_out_last", int'(out_last), 0);
    chk("rst_out_data", out_data, '0);
    chki("rst_ch_rd", int'(ch_rd), 0);
    chki("rst_frame_count", int'(frame_count), 0);
    chki("rst_overrun_cnt", int'(overrun_cnt), 0);
    chki("rst_busy", int'(busy), 0);

    // Heartbeat: all empty, header appears one edge after the third tick is taken
    n = 0;
    while (!out_valid && n < 400) begin
      step();
      n++;
    end
    chki("heartbeat_latency", n, (int'(idle_frames_th) + 1) * (int'(period_th) + 1) + 1);
    wait_trailers(trailers + 2, 600, "heartbeat_timeout");

    // Channels 2 and 5 with three words each
    period_th = 12'd200; idle_frames_th = 12'd2; ch_quota = 5'd16;
    clear_fifos();
    do_reset();
    fill(2, 3);
    fill(5, 3);
    drive_fifos();
    wait_trailers(trailers + 1, 600, "two_ch_timeout");
    chki("two_ch_drained", fifo[2].size() + fifo[5].size(), 0);

    // All channels four words, quota one: two consecutive frames
    fill(0, 4); fill(1, 4); fill(2, 4); fill(3, 4);
    fill(4, 4); fill(5, 4); fill(6, 4); fill(7, 4);
    ch_quota = 5'd0;
    drive_fifos();
    wait_trailers(trailers + 2, 900, "quota1_timeout");

    // Frame budget cap with a short period to provoke overruns
    period_th = 12'd3; ch_quota = 5'd31;
    clear_fifos();
    do_reset();
    fill(0, 40);
    drive_fifos();
    wait_trailers(trailers + 1, 200, "cap_timeout");
    flen    = 2 + FM + 1 + 1;
    exp_ovr = flen / (int'(period_th) + 1);
    chki("overrun_cnt", int'(overrun_cnt), exp_ovr);
    chki("ch0_remaining", fifo[0].size(), 40 - FM);

    // Reset in the middle of a data burst
    rd_s = 8'd0;
    n = 0;
    while (rd_s == 8'd0 && n < 100) begin
      step();
      n++;
    end
    chki("saw_read_before_reset", int'(rd_s != 8'd0), 1);
    reset = 1'b1;
    step();
    chki("midrst_out_valid", int'(out_valid), 0);
    chki("midrst_out_last", int'(out_last), 0);
    chk("midrst_out_data", out_data, '0);
    chki("midrst_ch_rd", int'(ch_rd), 0);
    chki("midrst_frame_count", int'(frame_count), 0);
    chki("midrst_overrun_cnt", int'(overrun_cnt), 0);
    chki("midrst_busy", int'(busy), 0);
    reset = 1'b0;

    // Randomised frames with a bursty downstream
    period_th = 12'd200; idle_frames_th = 12'd1; rdy_mode = 1;
    clear_fifos();
    do_reset();
    for (int f = 0; f < 12; f++) begin
      for (int c = 0; c < 8; c++) fill(c, $urandom_range(0, 4));
      ch_quota = 5'($urandom_range(0, 5));
      drive_fifos();
      wait_trailers(trailers + 1, 1200, "random_timeout");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
